// File: rtl/fsqrt_pkg.sv
// Shared types and constants for the iterative floating-point square root.
// FSQRT_EXC_EN selects IEEE special-value handling (signed zero, inf, NaN, invalid flag).
package fsqrt_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StNorm,
        StIter,
        StRound,
        StDone
    } state_e;

`ifdef FSQRT_EXC_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    // Exponent bias for an EW-bit exponent field.
    function automatic int unsigned fsqrt_bias(input int unsigned ew);
        return (32'd1 << (ew - 1)) - 32'd1;
    endfunction

    // Canonical quiet NaN {0, all-ones exponent, 1, zeros}, right-aligned in 64 bits.
    function automatic logic [63:0] fsqrt_qnan(input int unsigned ew, input int unsigned mw);
        return (((64'd1 << ew) - 64'd1) << mw) | (64'd1 << (mw - 1));
    endfunction

endpackage

// File: rtl/fsqrt_lzc.sv
// Combinational leading-zero counter for the stored mantissa field.
// count is MW when the input is all zero.
module fsqrt_lzc
    import fsqrt_pkg::*;
#(
    parameter int unsigned MW = 23
) (
    input  logic [MW-1:0]             data,
    output logic [$clog2(MW+1)-1:0]   count,
    output logic                      all_zero
);

    localparam int unsigned CW = $clog2(MW + 1);

    // Scan from LSB upward so the highest set bit wins.
    always_comb begin
        count    = CW'(MW);
        all_zero = 1'b1;
        for (int i = 0; i < MW; i++) begin
            if (data[i]) begin
                count    = CW'(MW - 1 - i);
                all_zero = 1'b0;
            end
        end
    end

endmodule

// File: rtl/fsqrt_pipe.sv
// Single-operand iterative square root for IEEE-style {sign, exp, mant} operands.
// One root bit per cycle by restoring digit recurrence, round-to-nearest on a guard bit.
// Optional feature: define FSQRT_EXC_EN for signed zero / inf / NaN / invalid handling.
module fsqrt_pipe
    import fsqrt_pkg::*;
#(
    parameter int unsigned EW = 8,
    parameter int unsigned MW = 23
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EW+MW:0]   in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EW+MW:0]   out_data,
    output logic             out_invalid
);

    localparam int unsigned DW   = EW + MW + 1;
    localparam int unsigned XW   = EW + 8;          // signed unbiased exponent workspace
    localparam int unsigned RW   = MW + 5;          // shifted partial remainder
    localparam int unsigned AW   = 2 * MW + 4;      // radicand, consumed two bits per step
    localparam int unsigned CW   = $clog2(MW + 1);
    localparam int unsigned NW   = $clog2(MW + 2) + 1;
    localparam int unsigned BIAS = fsqrt_bias(EW);
    localparam logic [DW-1:0] QNAN = DW'(fsqrt_qnan(EW, MW));

    state_e state_q, state_d;

    logic [DW-2:0] op_q;            // {exp, frac}; sign kept separately when used
    logic [AW-1:0] rad_q, rad_d;
    logic [MW+2:0] rem_q, rem_d;
    logic [MW+1:0] root_q, root_d;
    logic [EW-1:0] exp_q;
    logic [NW-1:0] cnt_q;
    logic          special_q;
    logic          invalid_q;
    logic [DW-1:0] spec_data_q;
    logic [DW-1:0] out_data_q;
    logic          out_invalid_q;

    logic [EW-1:0] op_exp;
    logic [MW-1:0] op_frac;
    logic [CW-1:0] lz;
    logic          frac_zero;

    logic [MW:0]          norm_mant;
    logic [MW+1:0]        mant_adj;
    logic signed [XW-1:0] e_unb;
    logic signed [XW-1:0] e_even;
    logic signed [XW-1:0] e_half;
    logic [EW-1:0]        norm_exp;
    logic [AW-1:0]        norm_rad;
    logic                 norm_special;
    logic                 norm_invalid;
    logic [DW-1:0]        norm_spec_data;

    logic [RW-1:0] rem_sh;
    logic [RW-1:0] trial;

    logic [MW+1:0] rnd_sum;
    logic [MW-1:0] rnd_frac;
    logic [EW-1:0] rnd_exp;

`ifdef FSQRT_EXC_EN
    logic sign_q;
`else
    logic unused_sign;
    assign unused_sign = in_data[DW-1];
`endif

    assign op_exp  = op_q[DW-2:MW];
    assign op_frac = op_q[MW-1:0];

    fsqrt_lzc #(
        .MW(MW)
    ) u_lzc (
        .data     (op_frac),
        .count    (lz),
        .all_zero (frac_zero)
    );

    // FSM next state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) state_d = StNorm;
            end
            StNorm:  state_d = StIter;
            StIter: begin
                if (cnt_q == NW'(MW + 1)) state_d = StRound;
            end
            StRound: state_d = StDone;
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Normalise the captured operand and classify special values.
    always_comb begin
        norm_mant      = '0;
        e_unb          = '0;
        norm_special   = 1'b0;
        norm_invalid   = 1'b0;
        norm_spec_data = '0;
        if (op_exp == '0) begin
            // Subnormal: bring the leading one up to the hidden-bit position.
            norm_mant = ({1'b0, op_frac} << lz) << 1;
            e_unb     = XW'(0) - XW'(BIAS) - XW'(lz);
        end else begin
            norm_mant = {1'b1, op_frac};
            e_unb     = XW'(op_exp) - XW'(BIAS);
        end
        // Odd exponent: fold one factor of two into the radicand.
        mant_adj = e_unb[0] ? {norm_mant, 1'b0} : {1'b0, norm_mant};
        e_even   = e_unb - XW'(e_unb[0]);
        e_half   = e_even >>> 1;
        norm_exp = EW'(e_half + XW'(BIAS));
        norm_rad = {mant_adj, {(MW + 2){1'b0}}};
`ifdef FSQRT_EXC_EN
        if ((&op_exp) && !frac_zero) begin
            norm_special   = 1'b1;
            norm_spec_data = QNAN;
        end else if ((op_exp == '0) && frac_zero) begin
            norm_special   = 1'b1;
            norm_spec_data = {sign_q, {(DW - 1){1'b0}}};
        end else if (sign_q) begin
            norm_special   = 1'b1;
            norm_invalid   = 1'b1;
            norm_spec_data = QNAN;
        end else if (&op_exp) begin
            norm_special   = 1'b1;
            norm_spec_data = {1'b0, op_q};
        end
`else
        if ((op_exp == '0) && frac_zero) begin
            norm_special   = 1'b1;
            norm_spec_data = '0;
        end
`endif
    end

    // One restoring recurrence step: try 4q+1 against the shifted remainder.
    always_comb begin
        rem_sh = {rem_q, rad_q[AW-1 -: 2]};
        trial  = {1'b0, root_q, 2'b01};
        rad_d  = {rad_q[AW-3:0], 2'b00};
        if (rem_sh >= trial) begin
            rem_d  = (MW + 3)'(rem_sh - trial);
            root_d = {root_q[MW:0], 1'b1};
        end else begin
            rem_d  = rem_sh[RW-3:0];
            root_d = {root_q[MW:0], 1'b0};
        end
    end

    // Round to nearest by adding the guard bit, renormalising on carry-out.
    always_comb begin
        rnd_sum = {1'b0, root_q[MW+1:1]} + (MW + 2)'(root_q[0]);
        if (rnd_sum[MW+1]) begin
            rnd_frac = rnd_sum[MW:1];
            rnd_exp  = exp_q + 1'b1;
        end else begin
            rnd_frac = rnd_sum[MW-1:0];
            rnd_exp  = exp_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers, advanced according to the current state.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q          <= '0;
            rad_q         <= '0;
            rem_q         <= '0;
            root_q        <= '0;
            exp_q         <= '0;
            cnt_q         <= '0;
            special_q     <= 1'b0;
            invalid_q     <= 1'b0;
            spec_data_q   <= '0;
            out_data_q    <= '0;
            out_invalid_q <= 1'b0;
`ifdef FSQRT_EXC_EN
            sign_q        <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        op_q   <= in_data[DW-2:0];
`ifdef FSQRT_EXC_EN
                        sign_q <= in_data[DW-1];
`endif
                    end
                end
                StNorm: begin
                    rad_q       <= norm_rad;
                    rem_q       <= '0;
                    root_q      <= '0;
                    cnt_q       <= '0;
                    exp_q       <= norm_exp;
                    special_q   <= norm_special;
                    invalid_q   <= norm_invalid;
                    spec_data_q <= norm_spec_data;
                end
                StIter: begin
                    rad_q  <= rad_d;
                    rem_q  <= rem_d;
                    root_q <= root_d;
                    cnt_q  <= cnt_q + 1'b1;
                end
                StRound: begin
                    out_data_q    <= special_q ? spec_data_q : {1'b0, rnd_exp, rnd_frac};
                    out_invalid_q <= special_q & invalid_q;
                end
                default: ;
            endcase
        end
    end

    assign out_data    = out_data_q;
    assign out_invalid = out_invalid_q;

endmodule

// File: doc/fsqrt_pipe.md
FSQRT_PIPE -- requirements
Module: fsqrt_pipe

Interface
REQ-001 SHALL have parameter EW, default 8, exponent field width in bits (range 4..11).
REQ-002 SHALL have parameter MW, default 23, stored mantissa field width in bits (range 4..52).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand present.
REQ-006 SHALL have port in_ready  output  1  block can accept an operand.
REQ-007 SHALL have port in_data  input  EW+MW+1  IEEE-style operand {sign, exp, mant}.
REQ-008 SHALL have port out_valid  output  1  result present.
REQ-009 SHALL have port out_ready  input  1  consumer takes result.
REQ-010 SHALL have port out_data  output  EW+MW+1  square root, same format as in_data.
REQ-011 SHALL have port out_invalid  output  1  invalid-operation flag qualified by out_valid.

Function
REQ-012 SHALL use an FSM with states IDLE, NORM, ITER, ROUND, DONE; only one operand is in flight.
REQ-013 SHALL assert in_ready only in IDLE; an input handshake is in_valid&in_ready at a rising edge, and in_data is captured then.
REQ-014 SHALL move IDLE->NORM on handshake, NORM->ITER after 1 cycle, ITER->ROUND after exactly MW+2 cycles, ROUND->DONE after 1 cycle, and DONE->IDLE on out_valid&out_ready.
REQ-015 SHALL assert out_valid only in DONE, first at edge k+MW+4 after a handshake at edge k (27 cycles for EW=8, MW=23), for every operand class.
REQ-016 SHALL hold out_data and out_invalid stable while out_valid=1 and out_ready=0.
REQ-017 SHALL, in NORM, normalise subnormal operands with a leading-zero count, giving hidden-bit mantissa m in [1,2) and unbiased exponent e.
REQ-018 SHALL shift m left by 1 when e is odd, making e even, and SHALL set the output exponent to e/2+bias, where bias=2^(EW-1)-1.
REQ-019 SHALL, in ITER, compute one root bit per cycle by restoring digit recurrence, producing MW+2 bits: hidden, MW fraction, guard.
REQ-020 SHALL round to nearest by adding the guard bit; if the carry reaches bit MW+1, it SHALL renormalise and increment the exponent.
REQ-021 SHALL map an input of +0 to +0, with exponent and mantissa all zero.
REQ-022 SHALL always produce a normal (never subnormal) result for a nonzero finite input.

Reset
REQ-023 SHALL, with rst=1 at a rising edge, enter IDLE and force out_valid=0, out_data=0, out_invalid=0, in_ready=1 on the next cycle.
REQ-024 SHALL have rst abandon any in-flight operation without producing a result; no handshake is accepted in a cycle where rst=1.

Configuration
REQ-025 SHALL support macro FSQRT_EXC_EN: when defined, -0 maps to -0; +inf maps to +inf; NaN maps to canonical qNaN {0, all-ones, 1, zeros}; negative nonzero (including -inf) maps to canonical qNaN with out_invalid=1.
REQ-026 SHALL, when FSQRT_EXC_EN is undefined, ignore the sign bit (output sign 0), treat all-ones exponents as ordinary finite values, and tie out_invalid to 0.
REQ-027 SHALL keep the latency of REQ-015 unchanged whether or not FSQRT_EXC_EN is defined.

Structure
REQ-028 SHALL place the FSM state typedef, the bias and canonical-qNaN constants (as functions of EW/MW), and the FSQRT_EXC_EN default in shared package fsqrt_pkg.
REQ-029 SHALL implement the leading-zero count as sub-module fsqrt_lzc (parametrised width MW, combinational, outputs count and all-zero flag).

Verification (EW=8, MW=23)
REQ-030 SHALL cover: in_data 0x40800000 (4.0) -> out_data 0x40000000, out_valid at edge k+27, out_invalid=0.
REQ-031 SHALL cover: in_data 0x40000000 (2.0) -> 0x3FB504F3; in_data 0x3F800000 -> 0x3F800000; in_data 0x00000000 -> 0x00000000.
REQ-032 SHALL cover: subnormal in_data 0x00000001 -> 0x1A3504F3.
REQ-033 SHALL cover: out_ready held 0 for 5 cycles after out_valid -> out_data stable, in_ready=0 throughout, handshake on 6th cycle, in_ready=1 the next cycle.
REQ-034 SHALL cover: rst pulsed 1 cycle mid-ITER -> no out_valid, in_ready=1 next cycle, next operand 0x40800000 yields 0x40000000.
REQ-035 SHALL cover, with FSQRT_EXC_EN defined: 0xBF800000 -> 0x7FC00000 with out_invalid=1; 0x7F800000 -> 0x7F800000 with out_invalid=0.
